// File: rtl/branch_tag_alloc.sv
//------------------------------------------------------------------------------
// Module   : branch_tag_alloc
// Brief    : Branch tag allocator with per-tag dependency masks, resolve/kill.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module branch_tag_alloc #(
  parameter int NUM_TAGS = 4,
  parameter int TAG_BITS = $clog2(NUM_TAGS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                alloc_req,
  output logic                alloc_ready,
  output logic [TAG_BITS-1:0] alloc_idx,
  output logic [NUM_TAGS-1:0] cur_mask,
  input  logic                resolve_valid,
  input  logic                resolve_mispred,
  input  logic [TAG_BITS-1:0] resolve_idx,
  input  logic                flush_all,
  output logic                clear_valid,
  output logic [TAG_BITS-1:0] clear_idx,
  output logic [NUM_TAGS-1:0] kill_mask,
  output logic [NUM_TAGS-1:0] busy_mask,
  output logic [TAG_BITS:0]   free_count
);

  logic [NUM_TAGS-1:0] r_busy;
  logic [NUM_TAGS-1:0] r_dep [NUM_TAGS];

  logic [NUM_TAGS-1:0] w_busy_nxt;
  logic [NUM_TAGS-1:0] w_dep_nxt [NUM_TAGS];
  logic [NUM_TAGS-1:0] w_res_onehot;
  logic [NUM_TAGS-1:0] w_dependents;
  logic [TAG_BITS-1:0] w_free_idx;
  logic [TAG_BITS:0]   w_pop;
  logic                w_res_busy;
  logic                w_hit;
  logic                w_correct;
  logic                w_mispred;
  logic                w_grant;

  always_comb begin
    w_res_onehot              = '0;
    w_res_onehot[resolve_idx] = 1'b1;
    w_res_busy = r_busy[resolve_idx];
    w_hit      = resolve_valid & w_res_busy & ~flush_all;
    w_correct  = w_hit & ~resolve_mispred;
    w_mispred  = w_hit & resolve_mispred;

    // Scan downward so the last assignment wins with the lowest free tag.
    w_free_idx = '0;
    for (int i = NUM_TAGS - 1; i >= 0; i--) begin
      if (!r_busy[i]) w_free_idx = TAG_BITS'(i);
    end

    w_pop = '0;
    for (int i = 0; i < NUM_TAGS; i++) begin
      w_pop = w_pop + (TAG_BITS + 1)'(r_busy[i]);
    end

    w_dependents = '0;
    for (int u = 0; u < NUM_TAGS; u++) begin
      w_dependents[u] = r_busy[u] & r_dep[u][resolve_idx];
    end

    alloc_ready = ~(&r_busy) & ~flush_all
                & ~(resolve_valid & resolve_mispred & w_res_busy);
    w_grant     = alloc_req & alloc_ready;
    alloc_idx   = w_free_idx;
    cur_mask    = r_busy & ~(w_correct ? w_res_onehot : '0);
    clear_valid = w_hit;
    clear_idx   = resolve_idx;

    if (flush_all)      kill_mask = r_busy;
    else if (w_mispred) kill_mask = w_dependents & ~w_res_onehot;
    else                kill_mask = '0;

    busy_mask  = r_busy;
    free_count = (TAG_BITS + 1)'(NUM_TAGS) - w_pop;
  end

  // Next state: retire/squash first, then load the newly granted tag's row.
  always_comb begin
    w_busy_nxt = r_busy;
    for (int u = 0; u < NUM_TAGS; u++) w_dep_nxt[u] = r_dep[u];

    if (w_hit) begin
      for (int u = 0; u < NUM_TAGS; u++) w_dep_nxt[u][resolve_idx] = 1'b0;
      w_busy_nxt[resolve_idx] = 1'b0;
    end
    if (w_mispred) w_busy_nxt = w_busy_nxt & ~w_dependents;

    if (w_grant) begin
      w_busy_nxt[w_free_idx] = 1'b1;
      w_dep_nxt[w_free_idx]  = cur_mask;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush_all) begin
      r_busy <= '0;
      for (int u = 0; u < NUM_TAGS; u++) r_dep[u] <= '0;
    end else begin
      r_busy <= w_busy_nxt;
      for (int u = 0; u < NUM_TAGS; u++) r_dep[u] <= w_dep_nxt[u];
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_branch_tag_alloc.sv
//------------------------------------------------------------------------------
// Module   : tb_branch_tag_alloc
// Brief    : Directed and randomized self-checking bench for branch_tag_alloc.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_branch_tag_alloc;

  localparam int N  = 4;
  localparam int TB = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          alloc_req;
  logic          alloc_ready;
  logic [TB-1:0] alloc_idx;
  logic [N-1:0]  cur_mask;
  logic          resolve_valid;
  logic          resolve_mispred;
  logic [TB-1:0] resolve_idx;
  logic          flush_all;
  logic          clear_valid;
  logic [TB-1:0] clear_idx;
  logic [N-1:0]  kill_mask;
  logic [N-1:0]  busy_mask;
  logic [TB:0]   free_count;

  always #5 clk = ~clk;

  branch_tag_alloc #(.NUM_TAGS(N), .TAG_BITS(TB)) dut (
    .clk(clk), .rst(rst),
    .alloc_req(alloc_req), .alloc_ready(alloc_ready), .alloc_idx(alloc_idx),
    .cur_mask(cur_mask),
    .resolve_valid(resolve_valid), .resolve_mispred(resolve_mispred),
    .resolve_idx(resolve_idx), .flush_all(flush_all),
    .clear_valid(clear_valid), .clear_idx(clear_idx), .kill_mask(kill_mask),
    .busy_mask(busy_mask), .free_count(free_count)
  );

  int n_checks = 0;
  int n_fail   = 0;
  // In-flight tags in program (allocation) order, oldest first.
  int order[$];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int qpos(input int t);
    foreach (order[i]) if (order[i] == t) return i;
    return -1;
  endfunction

  function automatic logic [N-1:0] qmask();
    logic [N-1:0] m = '0;
    foreach (order[i]) m[order[i]] = 1'b1;
    return m;
  endfunction

  function automatic int lowest_free();
    logic [N-1:0] m = qmask();
    for (int i = 0; i < N; i++) if (!m[i]) return i;
    return 0;
  endfunction

  task automatic drive(input logic a, input logic rv, input logic mp, input int ri, input logic fl);
    alloc_req       = a;
    resolve_valid   = rv;
    resolve_mispred = mp;
    resolve_idx     = TB'(ri);
    flush_all       = fl;
    #1;
  endtask

  // Check combinational outputs against the model, clock, advance the model.
  task automatic step();
    logic [N-1:0] m, e_kill, e_cur;
    int  ri, p;
    bit  hit, e_ready, grant;
    int  gidx;
    m       = qmask();
    ri      = int'(resolve_idx);
    p       = qpos(ri);
    hit     = resolve_valid && (p >= 0) && !flush_all;
    e_ready = (order.size() < N) && !flush_all && !(resolve_valid && resolve_mispred && p >= 0);
    e_kill  = '0;
    if (flush_all) e_kill = m;
    else if (hit && resolve_mispred)
      for (int i = p + 1; i < order.size(); i++) e_kill[order[i]] = 1'b1;
    e_cur = m;
    if (hit && !resolve_mispred) e_cur[ri] = 1'b0;
    gidx  = lowest_free();
    grant = alloc_req && e_ready;

    check_val("alloc_ready", 32'(alloc_ready), 32'(e_ready));
    check_val("kill_mask",   32'(kill_mask),   32'(e_kill));
    check_val("cur_mask",    32'(cur_mask),    32'(e_cur));
    check_val("clear_valid", 32'(clear_valid), 32'(hit));
    if (hit) check_val("clear_idx", 32'(clear_idx), 32'(ri));
    if (order.size() < N) check_val("alloc_idx", 32'(alloc_idx), 32'(gidx));

    @(posedge clk);
    if (flush_all) order.delete();
    else begin
      if (hit && !resolve_mispred) order.delete(p);
      if (hit && resolve_mispred) while (order.size() > p) void'(order.pop_back());
      if (grant) order.push_back(gidx);
    end
    #1;
    check_val("busy_mask",  32'(busy_mask),  32'(qmask()));
    check_val("free_count", 32'(free_count), 32'(N - order.size()));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 0, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    order.delete();
  endtask

  initial begin
    do_reset();
    check_val("rst_alloc_ready", 32'(alloc_ready), 32'd1);
    check_val("rst_alloc_idx",   32'(alloc_idx),   32'd0);
    check_val("rst_cur_mask",    32'(cur_mask),    32'd0);
    check_val("rst_busy_mask",   32'(busy_mask),   32'd0);
    check_val("rst_free_count",  32'(free_count),  32'd4);
    check_val("rst_clear_valid", 32'(clear_valid), 32'd0);
    check_val("rst_kill_mask",   32'(kill_mask),   32'd0);

    // Four back-to-back grants.
    for (int i = 0; i < N; i++) begin
      drive(1'b1, 1'b0, 1'b0, 0, 1'b0);
      check_val("seq_alloc_idx", 32'(alloc_idx), 32'(i));
      check_val("seq_cur_mask",  32'(cur_mask),  (32'd1 << i) - 32'd1);
      step();
    end
    drive(1'b0, 1'b0, 1'b0, 0, 1'b0);
    check_val("full_ready", 32'(alloc_ready), 32'd0);
    check_val("full_free",  32'(free_count),  32'd0);

    // Flush with all tags busy.
    drive(1'b1, 1'b0, 1'b0, 0, 1'b1);
    check_val("flush_kill",  32'(kill_mask),   32'hf);
    check_val("flush_ready", 32'(alloc_ready), 32'd0);
    step();
    drive(1'b0, 1'b0, 1'b0, 0, 1'b0);
    check_val("flush_idx", 32'(alloc_idx), 32'd0);

    // Mispredict of the middle of three tags.
    for (int i = 0; i < 3; i++) begin drive(1'b1, 1'b0, 1'b0, 0, 1'b0); step(); end
    drive(1'b0, 1'b1, 1'b1, 1, 1'b0);
    check_val("mis_kill", 32'(kill_mask), 32'h4);
    step();
    check_val("mis_busy", 32'(busy_mask),  32'h1);
    check_val("mis_free", 32'(free_count), 32'd3);

    // Resolve of an idle tag is ignored.
    drive(1'b0, 1'b1, 1'b0, 3, 1'b0);
    check_val("idle_cv",   32'(clear_valid), 32'd0);
    check_val("idle_kill", 32'(kill_mask),   32'd0);
    step();
    check_val("idle_busy", 32'(busy_mask), 32'h1);

    // Correct resolve with a concurrent grant, then prove dep[2] excludes tag 0.
    drive(1'b1, 1'b0, 1'b0, 0, 1'b0); step();
    drive(1'b1, 1'b1, 1'b0, 0, 1'b0);
    check_val("cr_cv",   32'(clear_valid), 32'd1);
    check_val("cr_cidx", 32'(clear_idx),   32'd0);
    check_val("cr_idx",  32'(alloc_idx),   32'd2);
    check_val("cr_cur",  32'(cur_mask),    32'h2);
    step();
    check_val("cr_busy", 32'(busy_mask), 32'h6);
    drive(1'b0, 1'b1, 1'b1, 1, 1'b0);
    check_val("cr_dep_kill", 32'(kill_mask), 32'h4);
    step();

    // Mispredict of the oldest tag blocks a concurrent grant.
    do_reset();
    drive(1'b1, 1'b0, 1'b0, 0, 1'b0); step();
    drive(1'b1, 1'b1, 1'b1, 0, 1'b0);
    check_val("mg_ready", 32'(alloc_ready), 32'd0);
    step();
    check_val("mg_busy", 32'(busy_mask), 32'h0);

    // Randomized traffic against the ordered-queue model.
    for (int c = 0; c < 3000; c++) begin
      int ri;
      if ($urandom_range(0, 63) == 0) begin
        do_reset();
        check_val("rr_busy", 32'(busy_mask), 32'd0);
        continue;
      end
      if (order.size() > 0 && $urandom_range(0, 3) != 0)
        ri = order[$urandom_range(0, order.size() - 1)];
      else
        ri = $urandom_range(0, N - 1);
      drive(1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 2) == 0), ri, 1'($urandom_range(0, 29) == 0));
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
